// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: sequences one SPI transaction around an external byte engine.
// The transaction runs CS assert, then for each byte a pre-wait and the byte itself,
// then CS deassert, a post-wait, and finally done.
// Optional feature macro: SPI_XFER_AUTO_POLL_EN adds periodic self-start. It adds the
// parameter POLL_PERIOD_CYC and the input i_poll_en.
module spi_xfer_sequencer #(
  parameter int unsigned MAX_BYTES     = 5,
  parameter int unsigned BYTE_CNT_W    = 3,
  parameter int unsigned PRE_WAIT_CYC  = 1500,
  parameter int unsigned POST_WAIT_CYC = 2500,
  parameter int unsigned CNT_W         = 16
`ifdef SPI_XFER_AUTO_POLL_EN
  ,
  parameter int unsigned POLL_PERIOD_CYC = 100000
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_n_reset,
`ifdef SPI_XFER_AUTO_POLL_EN
  input  logic                  i_poll_en,
`endif
  input  logic                  i_start,
  input  logic [BYTE_CNT_W-1:0] i_num_bytes,
  input  logic                  i_abort,
  input  logic                  i_fetch,
  input  logic                  i_byte_done,
  output logic                  o_byte_start,
  output logic [BYTE_CNT_W-1:0] o_byte_idx,
  output logic                  o_sclk_en,
  output logic                  o_cs_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_aborted
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CS_ASSERT   = 3'd1,
    PRE_WAIT    = 3'd2,
    BYTE        = 3'd3,
    CS_DEASSERT = 3'd4,
    POST_WAIT   = 3'd5,
    DONE        = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0]      PRE_LAST  = CNT_W'(PRE_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0]      POST_LAST = CNT_W'(POST_WAIT_CYC - 1);
  localparam logic [BYTE_CNT_W-1:0] MAX_N     = BYTE_CNT_W'(MAX_BYTES);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BYTE_CNT_W-1:0] idx_q, idx_d;
  logic [BYTE_CNT_W-1:0] nbytes_q, nbytes_d;
  logic                  aborted_q, aborted_d;
  logic [BYTE_CNT_W-1:0] num_clamped;
  logic                  start_req;
  logic                  done_exit;
  logic                  abort_ok;

`ifdef SPI_XFER_AUTO_POLL_EN
  localparam int unsigned         POLL_W    = $clog2(POLL_PERIOD_CYC + 1);
  localparam logic [POLL_W-1:0]   POLL_LAST = POLL_W'(POLL_PERIOD_CYC - 1);

  logic [POLL_W-1:0] poll_q, poll_d;
  logic              poll_tick;

  // Period counter restarts at every accepted start, so ticks are spaced from the previous start.
  always_comb begin
    poll_tick = i_poll_en && (poll_q == POLL_LAST);
    start_req = i_start || poll_tick;
    done_exit = i_poll_en || i_fetch;
    if (!i_poll_en || poll_tick || (state_q == IDLE && start_req)) begin
      poll_d = '0;
    end else begin
      poll_d = poll_q + POLL_W'(1);
    end
  end

  // Poll period counter register.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      poll_q <= '0;
    end else begin
      poll_q <= poll_d;
    end
  end
`else
  // Manual start and fetch only.
  always_comb begin
    start_req = i_start;
    done_exit = i_fetch;
  end
`endif

  // Clamp the requested byte count into 1..MAX_BYTES.
  always_comb begin
    if (i_num_bytes == '0) begin
      num_clamped = BYTE_CNT_W'(1);
    end else if (i_num_bytes > MAX_N) begin
      num_clamped = MAX_N;
    end else begin
      num_clamped = i_num_bytes;
    end
  end

  // Next-state, byte index and delay-counter logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nbytes_d  = nbytes_q;
    aborted_d = aborted_q;
    abort_ok  = i_abort && (state_q == CS_ASSERT || state_q == PRE_WAIT || state_q == BYTE);

    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d   = CS_ASSERT;
          nbytes_d  = num_clamped;
          aborted_d = 1'b0;
          idx_d     = '0;
        end
      end
      CS_ASSERT: state_d = PRE_WAIT;
      PRE_WAIT: begin
        if (cnt_q == PRE_LAST) state_d = BYTE;
      end
      BYTE: begin
        // The first BYTE cycle (cnt_q == 0) is the start pulse; byte_done counts only after it.
        if (i_byte_done && cnt_q != '0) begin
          if (idx_q == nbytes_q - BYTE_CNT_W'(1)) begin
            state_d = CS_DEASSERT;
          end else begin
            idx_d   = idx_q + BYTE_CNT_W'(1);
            state_d = PRE_WAIT;
          end
        end
      end
      CS_DEASSERT: state_d = POST_WAIT;
      POST_WAIT: begin
        if (cnt_q == POST_LAST) state_d = DONE;
      end
      DONE: begin
        if (done_exit) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // Abort overrides any concurrent byte completion; the index is left where it was.
    if (abort_ok) begin
      state_d   = CS_DEASSERT;
      idx_d     = idx_q;
      aborted_d = 1'b1;
    end

    // The counter reloads on every state change and saturates instead of wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      nbytes_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      nbytes_q  <= nbytes_d;
      aborted_q <= aborted_d;
    end
  end

  // Moore output decode; any unlisted encoding reads as CS high.
  always_comb begin
    o_cs_n       = !(state_q == CS_ASSERT || state_q == PRE_WAIT || state_q == BYTE);
    o_sclk_en    = (state_q == BYTE);
    o_byte_start = (state_q == BYTE) && (cnt_q == '0);
    o_busy       = !(state_q == IDLE || state_q == DONE);
    o_done       = (state_q == DONE);
    o_byte_idx   = idx_q;
    o_aborted    = aborted_q;
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer (default build, auto-poll disabled).
module tb_spi_xfer_sequencer;

  localparam int MAX_BYTES = 5;
  localparam int BW        = 3;
  localparam int PRE       = 4;
  localparam int POST      = 6;

  logic          clk = 1'b0;
  logic          n_reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          fetch = 1'b0;
  logic          byte_done = 1'b0;
  logic [BW-1:0] num_bytes = '0;
  logic          byte_start, sclk_en, cs_n, busy, done, aborted;
  logic [BW-1:0] byte_idx;

  spi_xfer_sequencer #(
    .MAX_BYTES    (MAX_BYTES),
    .BYTE_CNT_W   (BW),
    .PRE_WAIT_CYC (PRE),
    .POST_WAIT_CYC(POST),
    .CNT_W        (16)
  ) dut (
    .i_clk       (clk),
    .i_n_reset   (n_reset),
    .i_start     (start),
    .i_num_bytes (num_bytes),
    .i_abort     (abort),
    .i_fetch     (fetch),
    .i_byte_done (byte_done),
    .o_byte_start(byte_start),
    .o_byte_idx  (byte_idx),
    .o_sclk_en   (sclk_en),
    .o_cs_n      (cs_n),
    .o_busy      (busy),
    .o_done      (done),
    .o_aborted   (aborted)
  );

  always #5 clk = ~clk;

  // Observed output vector: {cs_n, byte_start, idx, sclk_en, busy, done}.
  typedef logic [7:0] obs_t;
  typedef struct {
    obs_t o;
    bit   drv_done;
  } step_t;

  obs_t  cur;
  assign cur = {cs_n, byte_start, byte_idx, sclk_en, busy, done};

  int    checks = 0;
  int    errors = 0;
  int    lat [MAX_BYTES];
  step_t tr[$];
  int    obs_cs_low;
  int    obs_starts;

  function automatic obs_t mk(bit c, bit s, int i, bit k, bit b, bit d);
    obs_t v;
    logic [BW-1:0] iv;
    iv = BW'(i);
    v  = {c, s, iv, k, b, d};
    return v;
  endfunction

  function automatic void push(obs_t o, bit d);
    step_t s;
    s.o        = o;
    s.drv_done = d;
    tr.push_back(s);
  endfunction

  // Reference timeline: one entry per cycle after start is accepted, from the protocol rules.
  function automatic void build_trace(input int req, input int abort_at);
    int n;
    int li;
    tr.delete();
    n = (req == 0) ? 1 : ((req > MAX_BYTES) ? MAX_BYTES : req);
    push(mk(0, 0, 0, 0, 1, 0), 0);
    for (int k = 0; k < n; k++) begin
      for (int p = 0; p < PRE; p++) push(mk(0, 0, k, 0, 1, 0), 0);
      for (int c = 0; c <= lat[k]; c++) push(mk(0, c == 0, k, 1, 1, 0), c == lat[k]);
    end
    if (abort_at >= 0) begin
      while (tr.size() > abort_at + 1) void'(tr.pop_back());
    end
    li = int'(tr[tr.size()-1].o[5:3]);
    for (int p = 0; p < 1 + POST; p++) push(mk(1, 0, li, 0, 1, 0), 0);
    push(mk(1, 0, li, 0, 0, 1), 0);
  endfunction

  function automatic int body_len(input int req);
    int n;
    int len;
    n   = (req == 0) ? 1 : ((req > MAX_BYTES) ? MAX_BYTES : req);
    len = 1;
    for (int k = 0; k < n; k++) len += PRE + lat[k] + 1;
    return len;
  endfunction

  // One transaction; stop_at >= 0 returns at the start of that cycle with no fetch.
  task automatic run_xfer(input int req, input int abort_at, input int stop_at, input bit spam);
    int hold;
    build_trace(req, abort_at);
    obs_cs_low = 0;
    obs_starts = 0;
    @(posedge clk); #1;
    num_bytes = BW'(req);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    num_bytes = BW'($urandom);
    for (int i = 0; i < tr.size(); i++) begin
      if (i == stop_at) begin
        byte_done = 1'b0;
        abort     = 1'b0;
        start     = 1'b0;
        return;
      end
      byte_done = tr[i].drv_done;
      abort     = (i == abort_at);
      start     = spam && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (cs_n === 1'b0) obs_cs_low++;
      if (byte_start === 1'b1) obs_starts++;
      checks++;
      if (cur !== tr[i].o) begin
        errors++;
        $display("FAIL trace req=%0d cyc=%0d got=%b want=%b", req, i, cur, tr[i].o);
      end
      @(posedge clk); #1;
    end
    byte_done = 1'b0;
    abort     = 1'b0;
    start     = 1'b0;
    hold = $urandom_range(1, 4);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || cs_n !== 1'b1 || aborted !== (abort_at >= 0)) begin
        errors++;
        $display("FAIL done_hold got done=%b busy=%b cs_n=%b ab=%b want ab=%0d",
                 done, busy, cs_n, aborted, abort_at >= 0);
      end
      @(posedge clk); #1;
    end
    fetch = 1'b1;
    start = 1'($urandom_range(0, 1));
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_at_fetch got=%b want=1", done);
    end
    @(posedge clk); #1;
    fetch = 1'b0;
    start = 1'b0;
    for (int h = 0; h < 2; h++) begin
      @(negedge clk);
      checks++;
      if (cur !== mk(1, 0, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL idle_after_fetch got=%b want=%b", cur, mk(1, 0, 0, 0, 0, 0));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #3 n_reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cur !== mk(1, 0, 0, 0, 0, 0) || aborted !== 1'b0) begin
      errors++;
      $display("FAIL reset got=%b ab=%b want=%b ab=0", cur, aborted, mk(1, 0, 0, 0, 0, 0));
    end
    @(posedge clk); #1;
    n_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (cur !== mk(1, 0, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL idle got=%b want=%b", cur, mk(1, 0, 0, 0, 0, 0));
      end
    end
  endtask

  task automatic test_full_xfer();
    for (int k = 0; k < MAX_BYTES; k++) lat[k] = 8;
    run_xfer(5, -1, -1, 1'b0);
    checks++;
    if (obs_cs_low !== 66) begin
      errors++;
      $display("FAIL cs_low_cycles got=%0d want=66", obs_cs_low);
    end
    checks++;
    if (obs_starts !== 5) begin
      errors++;
      $display("FAIL byte_starts got=%0d want=5", obs_starts);
    end
  endtask

  task automatic test_count_clamp();
    for (int k = 0; k < MAX_BYTES; k++) lat[k] = $urandom_range(1, 10);
    run_xfer(0, -1, -1, 1'b0);
    checks++;
    if (obs_starts !== 1) begin
      errors++;
      $display("FAIL clamp0_starts got=%0d want=1", obs_starts);
    end
    run_xfer(7, -1, -1, 1'b0);
    checks++;
    if (obs_starts !== 5) begin
      errors++;
      $display("FAIL clamp7_starts got=%0d want=5", obs_starts);
    end
  endtask

  task automatic test_abort();
    int req;
    for (int k = 0; k < MAX_BYTES; k++) lat[k] = 8;
    // Last cycle of the second BYTE, coincident with byte_done.
    run_xfer(5, 1 + (PRE + 9) + PRE + 8, -1, 1'b0);
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < MAX_BYTES; k++) lat[k] = $urandom_range(1, 10);
      req = $urandom_range(0, 7);
      run_xfer(req, $urandom_range(0, body_len(req) - 1), -1, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < MAX_BYTES; k++) lat[k] = 8;
    // Second cycle of byte 2's pre-wait.
    run_xfer(5, -1, 1 + 2 * (PRE + 9) + 1, 1'b0);
    #2 n_reset = 1'b0;
    #1;
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || byte_idx !== '0) begin
      errors++;
      $display("FAIL async_reset got cs_n=%b busy=%b done=%b idx=%0d want 1 0 0 0",
               cs_n, busy, done, byte_idx);
    end
    @(posedge clk); #1;
    n_reset = 1'b1;
    for (int k = 0; k < MAX_BYTES; k++) lat[k] = $urandom_range(1, 10);
    run_xfer(3, -1, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < MAX_BYTES; k++) lat[k] = $urandom_range(1, 12);
      run_xfer($urandom_range(0, 7), -1, -1, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < MAX_BYTES; k++) lat[k] = 1;
    run_xfer(2, -1, -1, 1'b0);
    run_xfer(4, -1, -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_xfer();
    test_count_clamp();
    test_abort();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
